// File: rtl/ram_adapter_pkg.sv
// Shared types and constants for the 32-bit word to 8-bit byte RAM adapter.
package ram_adapter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      RD_LAST,
      RD_DONE
   } state_t;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTE_W         = 8;

endpackage

// File: rtl/ram_4k.sv
// 4KB byte-wide RAM with one write port and a registered read port (1-cycle latency).
module ram_4k #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [ADDR_W-1:0] i_raddr,
   input  logic [7:0]        i_wdata,
   output logic [7:0]        o_rdata
);

   logic [7:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
      o_rdata <= mem[i_raddr];
   end

endmodule

// File: rtl/ram_word_adapter.sv
// Serialises 32-bit word writes/reads onto a byte-wide RAM, four byte cycles per word,
// little-endian byte order.
module ram_word_adapter
   import ram_adapter_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [3:0]        i_be,
   input  logic [31:0]       i_wdata,
   output logic              o_gnt,
   output logic              o_busy,
   output logic              o_rvalid,
   output logic [31:0]       o_rdata,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_waddr,
   output logic [ADDR_W-1:0] o_ram_raddr,
   output logic [7:0]        o_ram_wdata,
   input  logic [7:0]        i_ram_rdata
);

   localparam int unsigned WIDX_W = ADDR_W - 2;

   state_t            state;
   logic [1:0]        cnt;
   logic [1:0]        cnt_nxt;
   logic [1:0]        cnt_prv;
   logic [WIDX_W-1:0] word_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic              unused_addr_lsbs;

   assign unused_addr_lsbs = ^i_addr[1:0];

   assign o_gnt   = (state == IDLE) && i_req && !rst;
   assign o_busy  = (state != IDLE);
   assign cnt_nxt = cnt + 2'd1;
   assign cnt_prv = cnt - 2'd1;

   // RAM-side outputs are registered one step ahead so they line up with state/cnt;
   // read bytes arrive one cycle behind the address, hence the cnt_prv capture slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         word_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         o_rvalid    <= 1'b0;
         o_rdata     <= '0;
         o_ram_we    <= 1'b0;
         o_ram_waddr <= '0;
         o_ram_raddr <= '0;
         o_ram_wdata <= '0;
      end else begin
         o_rvalid <= 1'b0;
         o_ram_we <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_req) begin
                  word_q  <= i_addr[ADDR_W-1:2];
                  be_q    <= i_be;
                  wdata_q <= i_wdata;
                  cnt     <= '0;
                  if (i_we) begin
                     state       <= WR;
                     o_ram_we    <= i_be[0];
                     o_ram_waddr <= {i_addr[ADDR_W-1:2], 2'b00};
                     o_ram_wdata <= i_wdata[BYTE_W-1:0];
                  end else begin
                     state       <= RD;
                     o_ram_raddr <= {i_addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            WR: begin
               if (cnt == 2'd3) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt         <= cnt_nxt;
                  o_ram_we    <= be_q[cnt_nxt];
                  o_ram_waddr <= {word_q, cnt_nxt};
                  o_ram_wdata <= wdata_q[{cnt_nxt, 3'b000} +: BYTE_W];
               end
            end
            RD: begin
               if (cnt != 2'd0) begin
                  o_rdata[{cnt_prv, 3'b000} +: BYTE_W] <= i_ram_rdata;
               end
               if (cnt == 2'd3) begin
                  state <= RD_LAST;
               end else begin
                  cnt         <= cnt_nxt;
                  o_ram_raddr <= {word_q, cnt_nxt};
               end
            end
            RD_LAST: begin
               o_rdata[WORD_W-1 -: BYTE_W] <= i_ram_rdata;
               o_rvalid <= 1'b1;
               cnt      <= '0;
               state    <= RD_DONE;
            end
            RD_DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_word_adapter.sv
// Scoreboard bench: ram_word_adapter driving ram_4k, checked against a byte-array model.
module tb_ram_word_adapter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic        i_we = 1'b0;
   logic [11:0] i_addr = '0;
   logic [3:0]  i_be = '0;
   logic [31:0] i_wdata = '0;
   logic        o_gnt, o_busy, o_rvalid;
   logic [31:0] o_rdata;
   logic        o_ram_we;
   logic [11:0] o_ram_waddr, o_ram_raddr;
   logic [7:0]  o_ram_wdata, i_ram_rdata;

   ram_word_adapter #(.ADDR_W(12)) u_dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_be(i_be),
      .i_wdata(i_wdata), .o_gnt(o_gnt), .o_busy(o_busy), .o_rvalid(o_rvalid),
      .o_rdata(o_rdata), .o_ram_we(o_ram_we), .o_ram_waddr(o_ram_waddr),
      .o_ram_raddr(o_ram_raddr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
   );

   ram_4k #(.ADDR_W(12)) u_ram (
      .clk(clk), .i_we(o_ram_we), .i_waddr(o_ram_waddr), .i_raddr(o_ram_raddr),
      .i_wdata(o_ram_wdata), .o_rdata(i_ram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        rq[$];
   logic [7:0]  model [0:4095];
   int          wr_t = -100;
   int          rd_t = -100;
   logic [3:0]  wr_be = '0;
   logic [9:0]  wr_word = '0;
   logic [9:0]  rd_word = '0;
   logic [31:0] wr_data = '0;

   function automatic logic [11:0] a12(input int a);
      return 12'(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: read completions, hold of o_rdata, and the per-byte RAM port activity.
   logic [31:0] hold = '0;
   bit          hold_ok = 1'b0;
   exp_t        me;
   int          mk;

   always @(negedge clk) begin
      if (rst) begin
         hold_ok = 1'b0;
      end else begin
         if (o_rvalid) begin
            if (rq.size() == 0) begin
               chk("spurious_rvalid", 32'(o_rvalid), 32'd0);
            end else begin
               me = rq.pop_front();
               chk("rdata", o_rdata, me.data);
               chk("rvalid_cycle", 32'(cyc), 32'(me.cyc));
            end
            hold    = o_rdata;
            hold_ok = 1'b1;
         end else if (!o_busy && hold_ok) begin
            chk("rdata_hold", o_rdata, hold);
         end
         if (o_busy) chk("gnt_while_busy", 32'(o_gnt), 32'd0);
         mk = cyc - wr_t - 1;
         if (mk >= 0 && mk < 4) begin
            chk("ram_we", 32'(o_ram_we), 32'((int'(wr_be) >> mk) & 1));
            if (((int'(wr_be) >> mk) & 1) != 0) begin
               chk("ram_waddr", 32'(o_ram_waddr), 32'(int'(wr_word) * 4 + mk));
               chk("ram_wdata", 32'(o_ram_wdata), (wr_data >> (8 * mk)) & 32'hFF);
            end
         end else begin
            chk("ram_we_idle", 32'(o_ram_we), 32'd0);
         end
         mk = cyc - rd_t - 1;
         if (mk >= 0 && mk < 4) begin
            chk("ram_raddr", 32'(o_ram_raddr), 32'(int'(rd_word) * 4 + mk));
         end
      end
   end

   task automatic do_op(input bit we, input logic [11:0] addr, input logic [3:0] be,
                        input logic [31:0] data, output int tg);
      bit          got;
      int          w;
      logic [31:0] ed;
      got = 1'b0;
      @(negedge clk);
      i_req = 1'b1; i_we = we; i_addr = addr; i_be = be; i_wdata = data;
      for (int n = 0; n < 40 && !got; n++) begin
         #1;
         if (o_gnt) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         chk("gnt_timeout", 32'd0, 32'd1);
         i_req = 1'b0;
         tg = -1;
         return;
      end
      tg = cyc;
      w  = int'(addr) >> 2;
      if (we) begin
         for (int k = 0; k < 4; k++) begin
            if (((int'(be) >> k) & 1) != 0) model[a12(w * 4 + k)] = 8'(data >> (8 * k));
         end
         wr_t = tg; wr_be = be; wr_word = 10'(w); wr_data = data;
      end else begin
         ed = {model[a12(w * 4 + 3)], model[a12(w * 4 + 2)],
               model[a12(w * 4 + 1)], model[a12(w * 4)]};
         rq.push_back('{ed, tg + 6});
         rd_t = tg; rd_word = 10'(w);
      end
      @(posedge clk);
      #1 i_req = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 60 && rq.size() > 0; n++) @(negedge clk);
      if (rq.size() > 0) begin
         chk("rvalid_timeout", 32'(rq.size()), 32'd0);
         rq.delete();
      end
      @(negedge clk);
   endtask

   int t0, t1, tr;

   initial begin
      // Reset state, with a request pending to show reset beats grant
      i_req = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_gnt", 32'(o_gnt), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_rvalid", 32'(o_rvalid), 32'd0);
      chk("rst_ram_we", 32'(o_ram_we), 32'd0);
      chk("rst_rdata", o_rdata, 32'd0);
      chk("rst_waddr", 32'(o_ram_waddr), 32'd0);
      chk("rst_raddr", 32'(o_ram_raddr), 32'd0);
      @(negedge clk);
      rst = 1'b0; i_req = 1'b0;

      // Full word round trip
      do_op(1'b1, 12'h010, 4'hF, 32'h1234_5678, t0);
      do_op(1'b0, 12'h010, 4'h0, 32'h0, t0);
      drain();
      chk("t1_rdata", o_rdata, 32'h1234_5678);
      chk("t1_b0", 32'(u_ram.mem[12'h010]), 32'h78);
      chk("t1_b1", 32'(u_ram.mem[12'h011]), 32'h56);
      chk("t1_b2", 32'(u_ram.mem[12'h012]), 32'h34);
      chk("t1_b3", 32'(u_ram.mem[12'h013]), 32'h12);

      // Partial byte-enable write over preloaded word
      do_op(1'b1, 12'h020, 4'hF, 32'hAABB_CCDD, t0);
      do_op(1'b1, 12'h020, 4'h5, 32'h1111_2222, t0);
      do_op(1'b0, 12'h020, 4'h0, 32'h0, t0);
      drain();
      chk("t2_rdata", o_rdata, 32'hAA11_CC22);

      // Unaligned address bits ignored
      do_op(1'b1, 12'h033, 4'hF, 32'hCAFE_0123, t0);
      do_op(1'b0, 12'h031, 4'h0, 32'h0, t0);
      drain();
      chk("t3_b0", 32'(u_ram.mem[12'h030]), 32'h23);
      chk("t3_b3", 32'(u_ram.mem[12'h033]), 32'hCA);

      // Grant spacing: read->read 7, write->write 5
      do_op(1'b0, 12'h010, 4'h0, 32'h0, t0);
      do_op(1'b0, 12'h020, 4'h0, 32'h0, t1);
      chk("t4_rd_spacing", 32'(t1 - t0), 32'd7);
      do_op(1'b1, 12'h040, 4'hF, 32'h0BAD_F00D, t0);
      do_op(1'b1, 12'h044, 4'h3, 32'h5566_7788, t1);
      chk("t4_wr_spacing", 32'(t1 - t0), 32'd5);
      drain();

      // Top-of-memory word stays within its own word
      do_op(1'b1, 12'h000, 4'hF, 32'h0102_0304, t0);
      do_op(1'b1, 12'hFFC, 4'hF, 32'hDEAD_BEEF, t0);
      do_op(1'b0, 12'hFFC, 4'h0, 32'h0, t0);
      drain();
      chk("t6_rdata", o_rdata, 32'hDEAD_BEEF);
      chk("t6_fff", 32'(u_ram.mem[12'hFFF]), 32'hDE);
      chk("t6_ffc", 32'(u_ram.mem[12'hFFC]), 32'hEF);
      chk("t6_000", 32'(u_ram.mem[12'h000]), 32'h04);

      // Reset in the middle of a read, with a request pending across reset
      do_op(1'b0, 12'h010, 4'h0, 32'h0, tr);
      while (cyc < tr + 3) @(negedge clk);
      rst = 1'b1; rd_t = -100; rq.delete();
      i_req = 1'b1; i_we = 1'b1; i_addr = 12'h100; i_be = 4'h0; i_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      #1;
      chk("t5_busy", 32'(o_busy), 32'd0);
      chk("t5_rvalid", 32'(o_rvalid), 32'd0);
      chk("t5_rdata", o_rdata, 32'd0);
      chk("t5_gnt_in_rst", 32'(o_gnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_regrant", 32'(o_gnt), 32'd1);
      wr_t = cyc; wr_be = 4'h0; wr_word = 10'h040; wr_data = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 i_req = 1'b0;

      // Randomised traffic over a small initialised window
      for (int w = 12'h40; w < 12'h50; w++) begin
         do_op(1'b1, a12(w * 4), 4'hF, $urandom, t0);
      end
      for (int n = 0; n < 80; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op(1'($urandom_range(0, 1)), a12((12'h40 + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3)),
               4'($urandom_range(0, 15)), $urandom, t0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
